// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF response collector.
// The collector FSM state, the select-width rule shared with the controller, and saturating increment.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } collector_state_t;

  localparam int NUM_LOOPS_DEFAULT = 4;

  function automatic int sel_bits_for(input int num_loops);
    return $clog2(num_loops - 1) + 1;
  endfunction

  localparam int SEL_BITS = sel_bits_for(NUM_LOOPS_DEFAULT);

  // Increments a value that is 'width' bits wide and holds it once it reaches all ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [32:0] max_value;
    max_value = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= max_value) begin
      return value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/puf_response_collector_if.sv
// Controller-to-collector strobe bus and the collector's response/status signals.
interface puf_response_collector_if #(
  parameter int NUM_LOOPS = 4,
  parameter int SEL_BITS  = puf_pkg::sel_bits_for(NUM_LOOPS)
);
  logic                 start;
  logic                 done;
  logic                 reset_puf;
  logic [SEL_BITS-1:0]  select_puf;
  logic                 enable_puf;
  logic                 store_response_puf;
  logic [NUM_LOOPS-1:0] response;
  logic                 response_valid;
  logic                 busy;

  modport master (
    output start, done, reset_puf, select_puf, enable_puf, store_response_puf,
    input  response, response_valid, busy
  );

  modport slave (
    input  start, done, reset_puf, select_puf, enable_puf, store_response_puf,
    output response, response_valid, busy
  );
endinterface

// File: rtl/puf_response_collector_ro_edge_counter.sv
// One oscillator channel: synchroniser chain, rising-edge detect and a saturating edge counter.
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int COUNTER_BITS = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ro,
  input  logic                    clear,
  input  logic                    enable,
  output logic [COUNTER_BITS-1:0] count
);

  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    prev_reg;
  logic [COUNTER_BITS-1:0] count_reg;
  logic [COUNTER_BITS-1:0] count_next;
  logic                    rise;

  assign rise       = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign count_next = COUNTER_BITS'(sat_inc(32'(count_reg), COUNTER_BITS));
  assign count      = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      // Clearing wins over counting so a window always starts from zero.
      if (clear) begin
        count_reg <= '0;
      end else if (enable && rise) begin
        count_reg <= count_next;
      end
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// PUF-side responder: counts the selected oscillator pair, votes per loop and presents the response.
// Optional macro PUF_RAW_COUNT_EN exposes the compared counts on every store for characterisation.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int NUM_LOOPS        = 4,
  parameter int COUNTER_BITS     = 16,
  parameter int REPETITIONS_BITS = 16,
  parameter int REPETITIONS      = 2,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*NUM_LOOPS-1:0]  ro_in,
`ifdef PUF_RAW_COUNT_EN
  output logic [COUNTER_BITS-1:0] raw_cnt_a,
  output logic [COUNTER_BITS-1:0] raw_cnt_b,
  output logic                    raw_valid,
`endif
  puf_response_collector_if.slave bus
);

  localparam int SEL_W = sel_bits_for(NUM_LOOPS);

  collector_state_t        state_reg;
  logic                    done_reg;
  logic [NUM_LOOPS-1:0]    response_reg;
  logic                    response_valid_reg;
  logic                    busy_reg;

  logic [NUM_LOOPS-1:0]    ro_a_vec;
  logic [NUM_LOOPS-1:0]    ro_b_vec;
  logic                    ro_a_sel;
  logic                    ro_b_sel;
  logic                    sel_in_range;
  logic [COUNTER_BITS-1:0] cnt_a;
  logic [COUNTER_BITS-1:0] cnt_b;
  logic                    a_gt_b;
  logic                    store_hit;
  logic                    votes_clear;
  logic [NUM_LOOPS-1:0]    vote_result;

  // Out-of-range selects leave both counters fed with a quiet zero.
  always_comb begin
    ro_a_sel     = 1'b0;
    ro_b_sel     = 1'b0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (bus.select_puf == SEL_W'(i)) begin
        ro_a_sel     = ro_a_vec[i];
        ro_b_sel     = ro_b_vec[i];
        sel_in_range = 1'b1;
      end
    end
  end

  assign a_gt_b      = cnt_a > cnt_b;
  assign store_hit   = (state_reg == RUN) && bus.store_response_puf && sel_in_range;
  assign votes_clear = bus.start && (state_reg != FINAL);

  ro_edge_counter #(
    .COUNTER_BITS (COUNTER_BITS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_cnt_a (
    .clk    (clk),
    .reset  (reset),
    .ro     (ro_a_sel),
    .clear  (bus.reset_puf),
    .enable (bus.enable_puf),
    .count  (cnt_a)
  );

  ro_edge_counter #(
    .COUNTER_BITS (COUNTER_BITS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_cnt_b (
    .clk    (clk),
    .reset  (reset),
    .ro     (ro_b_sel),
    .clear  (bus.reset_puf),
    .enable (bus.enable_puf),
    .count  (cnt_b)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOOPS; gi++) begin : vote_gen
      logic [REPETITIONS_BITS-1:0] votes_reg;
      logic [REPETITIONS_BITS-1:0] votes_next;

      assign ro_a_vec[gi] = ro_in[2*gi];
      assign ro_b_vec[gi] = ro_in[2*gi+1];
      assign votes_next   = REPETITIONS_BITS'(sat_inc(32'(votes_reg), REPETITIONS_BITS));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          votes_reg <= '0;
        end else if (votes_clear) begin
          votes_reg <= '0;
        end else if (store_hit && a_gt_b && (bus.select_puf == SEL_W'(gi))) begin
          votes_reg <= votes_next;
        end
      end

      // Strict majority: ties resolve to 0.
      assign vote_result[gi] = {votes_reg, 1'b0} > (REPETITIONS_BITS+1)'(REPETITIONS);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      done_reg           <= 1'b0;
      response_reg       <= '0;
      response_valid_reg <= 1'b0;
      busy_reg           <= 1'b0;
    end else begin
      // A start in the same cycle as done must not let that done end the new run.
      done_reg <= bus.done && !bus.start;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg          <= RUN;
            response_valid_reg <= 1'b0;
            busy_reg           <= 1'b1;
          end
        end
        RUN: begin
          if (bus.start) begin
            state_reg          <= RUN;
            response_valid_reg <= 1'b0;
            busy_reg           <= 1'b1;
          end else if (done_reg) begin
            state_reg <= FINAL;
          end
        end
        FINAL: begin
          response_reg       <= vote_result;
          response_valid_reg <= 1'b1;
          busy_reg           <= 1'b0;
          state_reg          <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.response       = response_reg;
  assign bus.response_valid = response_valid_reg;
  assign bus.busy           = busy_reg;

`ifdef PUF_RAW_COUNT_EN
  logic [COUNTER_BITS-1:0] raw_cnt_a_reg;
  logic [COUNTER_BITS-1:0] raw_cnt_b_reg;
  logic                    raw_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_cnt_a_reg <= '0;
      raw_cnt_b_reg <= '0;
      raw_valid_reg <= 1'b0;
    end else begin
      raw_valid_reg <= store_hit;
      if (store_hit) begin
        raw_cnt_a_reg <= cnt_a;
        raw_cnt_b_reg <= cnt_b;
      end
    end
  end

  assign raw_cnt_a = raw_cnt_a_reg;
  assign raw_cnt_b = raw_cnt_b_reg;
  assign raw_valid = raw_valid_reg;
`endif

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- PUF-side responder to the ring-oscillator PUF controller state machine.
- Consumes the controller's control strobes: reset_puf, select_puf, enable_puf, store_response_puf, plus start and done.
- For each loop, counts edges of that loop's oscillator pair during the enable window and compares the two counts on store.
- Takes a majority vote over repetitions and presents a NUM_LOOPS-bit response with a valid flag.

Parameters:
- NUM_LOOPS, 4: number of oscillator pairs; response width.
- COUNTER_BITS, 16: width of each edge counter.
- REPETITIONS_BITS, 16: width of the vote counters and of REPETITIONS.
- REPETITIONS, 2: evaluations per loop; must match the controller.
- SYNC_STAGES, 2: synchroniser depth on oscillator inputs; must be 2 or more.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- ro_in, input, 2*NUM_LOOPS: oscillator outputs; loop i uses bit 2i (A) and bit 2i+1 (B).
- start, input, 1: one-cycle pulse that begins a new challenge run.
- done, input, 1: controller completion flag.
- reset_puf, input, 1: clears the edge counters.
- select_puf, input, $clog2(NUM_LOOPS-1)+1: loop index.
- enable_puf, input, 1: counting window.
- store_response_puf, input, 1: one-cycle compare/vote strobe.
- response, output, NUM_LOOPS: voted response.
- response_valid, output, 1: response is final.
- busy, output, 1: a run is in progress.

Behaviour:
- Reset: response=0, response_valid=0, busy=0, counters=0, votes=0, state=IDLE.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Oscillator inputs: each ro_in bit passes through a SYNC_STAGES flop chain plus one edge-detect flop.
- Rising edge: synchronised sample = 1 and previous sample = 0.
- States:
  - IDLE: start -> RUN; clears all votes, response_valid<=0, busy<=1.
  - RUN: normal operation; done=1 (level-sensitive) -> FINAL.
  - FINAL: one cycle; latches response, response_valid<=1, busy<=0 -> IDLE.
- Counters, cnt_a and cnt_b (one pair, muxed by select_puf sampled each cycle):
  - reset_puf=1 clears both; this has priority over counting.
  - Otherwise, if enable_puf=1, each counter increments in the cycle its synchronised edge is seen.
  - Counters saturate at 2^COUNTER_BITS-1; no wrap.
- Store (store_response_puf=1 in RUN):
  - bit = (cnt_a > cnt_b); equal counts give 0.
  - If bit=1, votes[select_puf]++, saturating.
  - Vote update is visible the next cycle.
  - A store in the same cycle as reset_puf compares the pre-clear values.
- Out-of-range select_puf (>= NUM_LOOPS): store and vote are ignored.
- Response bit i = 1 iff 2*votes[i] > REPETITIONS; ties give 0.
- Latency: response_valid rises 2 cycles after the first clk edge that samples done=1.
- response_valid stays high until the next start or reset.
- Strobes in IDLE: store, enable and reset_puf strobes still operate the counters, but votes do not change.
- start in RUN: restarts the run (votes cleared, response_valid stays 0).
- start coinciding with done: start wins.
- Reset mid-run: aborts immediately to the reset values.

Optional Feature:
- Macro: PUF_RAW_COUNT_EN.
- Defined:
  - Adds outputs raw_cnt_a and raw_cnt_b (COUNTER_BITS each) and raw_valid (1).
  - On every store in RUN, they register the compared counts; raw_valid pulses for 1 cycle.
  - All three reset to 0.
  - Used for oscillator characterisation.
- Undefined: the ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package puf_pkg:
  - collector state enum typedef (IDLE, RUN, FINAL);
  - localparam SEL_BITS = $clog2(NUM_LOOPS-1)+1, shared with the controller;
  - a saturating-increment function.
- One sub-module, ro_edge_counter: synchroniser, edge detect and saturating counter for a single oscillator. It is instantiated twice, for A and B.

Test Plan:
- Basic run:
  - Stimulus: NUM_LOOPS=4, REPETITIONS=2; start, then per loop reset_puf, enable 8 cycles, store. A toggles every 2 clks, B every 4 clks on loops 0 and 2; B faster on loops 1 and 3; then done.
  - Required: response=4'b0101, response_valid=1 two cycles after done.
- Tie and majority:
  - Stimulus: loop 1 gets one A>B repetition and one equal repetition.
  - Required: votes=1, response[1]=0. Three repetitions with 2 wins gives response[1]=1.
- Saturation:
  - Stimulus: COUNTER_BITS=4, 40 edges on A.
  - Required: cnt_a holds 15, no wrap; compare against B=3 gives bit 1.
- reset_puf with store in the same cycle:
  - Stimulus: A=5, B=2.
  - Required: vote increments; counters read 0 the next cycle.
- Asynchronous reset mid-RUN, then restart:
  - Stimulus: assert reset without a clock edge; then start again.
  - Required: outputs 0 immediately; no stale votes carried into the new run.
- PUF_RAW_COUNT_EN defined:
  - Stimulus: store with A=9, B=6.
  - Required: raw_cnt_a=9, raw_cnt_b=6, raw_valid pulses for 1 cycle.
